hub_sys: RTL and testbench
==========================

HUB_SYS -- requirements
Module: hub_sys

Interface
REQ-001 The block SHALL have parameter NCOG, default 8, meaning cog count, power of two, 2..16.
REQ-002 The block SHALL have parameter NLOCK, default 8, meaning lock count, 1..32.
REQ-003 The block SHALL have parameter OWN_REL, default 1, meaning COGSTOP frees locks owned by the stopped cog.
REQ-004 The block SHALL have these ports, with its single clock clk_cog and an asynchronous, active-high reset res:
- clk_cog  in  1  clock
- res  in  1  reset
- ena_bus  in  1  hub slot advance strobe
- bus_sel  out  NCOG  one-hot slot owner
- req_e  in  1  sys request from slot owner
- req_op  in  3  opcode: 000 CLKSET, 001 COGID, 010 COGINIT, 011 COGSTOP, 100 LOCKNEW, 101 LOCKRET, 110 LOCKSET, 111 LOCKCLR
- req_d  in  32  operand: id d[4:0], newx d[5], ptr d[31:6]
- rsp_q  out  5  result id
- rsp_c  out  1  result flag
- rsp_ack  out  NCOG  one-hot completion
- cog_ena  out  NCOG  cog run enables
- ptr_w  out  NCOG  start-pointer write strobes
- ptr_d  out  26  start pointer
- cfg  out  8  clock config

Function
REQ-005 bus_sel SHALL rotate one-hot toward the MSB on each clk_cog edge with ena_bus high, wrapping from bit NCOG-1 to bit 0.
REQ-006 Stage 1 SHALL capture req_e, req_op, req_d and the requester index (encoded bus_sel) on edge E when ena_bus is high.
REQ-007 Stage 2 SHALL execute the captured request on edge E+1 when ena_bus is high: update state, register rsp_q/rsp_c, set valid.
REQ-008 rsp_ack SHALL equal the one-hot of the stage-2 requester while stage-2 valid is high, else zero; this makes acknowledge latency exactly two slots.
REQ-009 Without ena_bus, all pipeline and state registers SHALL hold.
REQ-010 The free-slot encoder SHALL return the lowest index whose enable bit is 0; "all" SHALL be high when no bit is 0 (cog_e for cogs, lock_e[NLOCK-1:0] for locks).
REQ-011 Each opcode SHALL behave as follows; op uses id = d[IDW-1:0], IDW = clog2 of the relevant count, and higher id bits are ignored:
- CLKSET: cfg <= d[7:0].
- COGID: rsp_q = requester index.
- COGINIT: target = newx ? free cog : id. When newx and all: no state change, rsp_c=1, no ptr_w. Otherwise cog_e[target] <= 1, ptr_w[target] pulses for one cycle, cog_ena[target] is forced 0 for that cycle, rsp_q=target, rsp_c=all.
- COGSTOP: cog_e[id] <= 0. If OWN_REL, locks with owner==id are cleared in lock_e.
- LOCKNEW: when not all, lock_e[free] <= 1 and owner <= requester; rsp_q=free, rsp_c=all.
- LOCKRET: lock_e[id] <= 0.
- LOCKSET/LOCKCLR: rsp_c = prior lock_state[id]; lock_state[id] <= 1/0.
REQ-012 rsp_c for COGID, CLKSET, COGSTOP and LOCKRET SHALL be "all" of the class selected by op[2].
REQ-013 cog_ena SHALL be registered from cog_e under ena_bus, one cycle behind cog_e.
REQ-014 ptr_d SHALL be the stage-2 d[31:6].
REQ-015 A COGSTOP targeting the requester itself SHALL still produce its rsp_ack.

Reset
REQ-016 On res high, asynchronously: bus_sel=1, cog_e=1 (cog 0 runs), cog_ena=0, lock_e=0, lock_state=0, owners=0, cfg=0, pipeline valid=0, rsp_q=0, rsp_c=0.
REQ-017 Reset asserted mid-request SHALL discard the request with no rsp_ack and no ptr_w.

Structure
REQ-018 The opcode constants and field positions (id, newx, ptr) SHALL live in shared package hub_pkg.
REQ-019 The lowest-free encoder SHALL be a sub-module hub_ffz with a width parameter, instanced once for cogs and once for locks.

Verification
REQ-020 Reset then 16 ena_bus pulses -> bus_sel cycles 01,02,...,80,01 (NCOG=8); cog_ena=01 after the first pulse.
REQ-021 Slot 3 COGINIT newx=1, ptr=0x1234 -> rsp_ack=0x08 two slots later, rsp_q=1, ptr_w=0x02 for 1 cycle, ptr_d=0x1234, cog_ena then 0x03.
REQ-022 Launch 7 cogs, then COGINIT newx -> rsp_c=1, cog_e unchanged at 0xFF, ptr_w never asserted.
REQ-023 LOCKNEW from cog 2 returns 0; LOCKSET 0 -> rsp_c=0; second LOCKSET 0 -> rsp_c=1; COGSTOP 2 (OWN_REL=1) -> lock_e[0]=0.
REQ-024 NLOCK=32, NCOG=16: CLKSET 0x6F -> cfg=0x6F; COGID from slot 15 -> rsp_q=15.
REQ-025 res pulsed between capture and execute of a COGINIT -> no ptr_w, rsp_ack=0, cog_e=0x01.

Source files
------------

// File: rtl/hub_pkg.sv
// Shared definitions for the hub system block.
// Holds the system-request opcode encoding, the operand field positions
// (id, newx, start pointer) and a small index-width helper.
package hub_pkg;

  typedef enum logic [2:0] {
    OP_CLKSET  = 3'b000,
    OP_COGID   = 3'b001,
    OP_COGINIT = 3'b010,
    OP_COGSTOP = 3'b011,
    OP_LOCKNEW = 3'b100,
    OP_LOCKRET = 3'b101,
    OP_LOCKSET = 3'b110,
    OP_LOCKCLR = 3'b111
  } hub_op_e;

  localparam int ID_LSB   = 0;
  localparam int ID_MSB   = 4;
  localparam int NEWX_BIT = 5;
  localparam int PTR_LSB  = 6;
  localparam int PTR_MSB  = 31;
  localparam int PTR_W    = PTR_MSB - PTR_LSB + 1;
  localparam int CFG_W    = 8;
  localparam int RSP_Q_W  = 5;

  // Index width for a set of n items; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub_ffz.sv
// Lowest-free encoder.
// Ports:
//   vec  in  W   enable bits (1 = in use)
//   idx  out IW  lowest index whose bit is 0 (0 when none)
//   all  out 1   high when every bit of vec is 1
module hub_ffz
  import hub_pkg::*;
#(
  parameter int W  = 8,
  parameter int IW = idx_w(W)
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          all
);

  // Scan from the top so the last hit taken is the lowest free index.
  always_comb begin
    idx = '0;
    all = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      if (!vec[i]) begin
        idx = IW'(i);
        all = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hub_sys.sv
// Hub system-request unit: rotates the hub slot among cogs, accepts one
// system request per slot from the slot owner, and executes it one slot
// later (cog start/stop, lock allocation/set/clear, clock config).
// Ports:
//   clk_cog  clock;  res  async active-high reset
//   ena_bus  slot advance strobe; bus_sel one-hot slot owner
//   req_e/req_op/req_d   request from the slot owner
//   rsp_q/rsp_c/rsp_ack  result id, flag, one-hot completion
//   cog_ena  cog run enables; ptr_w/ptr_d start-pointer write; cfg clock config
module hub_sys
  import hub_pkg::*;
#(
  parameter int NCOG    = 8,
  parameter int NLOCK   = 8,
  parameter bit OWN_REL = 1'b1
) (
  input  logic                 clk_cog,
  input  logic                 res,
  input  logic                 ena_bus,
  output logic [NCOG-1:0]      bus_sel,
  input  logic                 req_e,
  input  logic [2:0]           req_op,
  input  logic [31:0]          req_d,
  output logic [RSP_Q_W-1:0]   rsp_q,
  output logic                 rsp_c,
  output logic [NCOG-1:0]      rsp_ack,
  output logic [NCOG-1:0]      cog_ena,
  output logic [NCOG-1:0]      ptr_w,
  output logic [PTR_W-1:0]     ptr_d,
  output logic [CFG_W-1:0]     cfg
);

  localparam int CW = idx_w(NCOG);
  localparam int LW = idx_w(NLOCK);

  function automatic logic [CW-1:0] enc_oh(input logic [NCOG-1:0] oh);
    enc_oh = '0;
    for (int i = 0; i < NCOG; i++) begin
      if (oh[i]) enc_oh = enc_oh | CW'(i);
    end
  endfunction

  logic                vld_p1, vld_p2;
  hub_op_e             op_p1;
  logic [31:0]         d_p1;
  logic [CW-1:0]       rid_p1, rid_p2;
  logic [PTR_W-1:0]    ptr_p2;

  logic [NCOG-1:0]     cog_e, cog_e_n, cog_ena_r, ptr_w_n;
  logic [NLOCK-1:0]    lock_e, lock_e_n, lock_st, lock_st_n;
  logic [CW-1:0]       owner   [NLOCK];
  logic [CW-1:0]       owner_n [NLOCK];
  logic [CFG_W-1:0]    cfg_n;
  logic [RSP_Q_W-1:0]  rsp_q_n;
  logic                rsp_c_n;

  logic [CW-1:0]       cog_free, cog_id, cog_tgt;
  logic                cog_all, newx;
  logic [LW-1:0]       lock_free, lock_id;
  logic                lock_all, lock_ok;

  hub_ffz #(.W(NCOG))  u_ffz_cog  (.vec(cog_e),  .idx(cog_free),  .all(cog_all));
  hub_ffz #(.W(NLOCK)) u_ffz_lock (.vec(lock_e), .idx(lock_free), .all(lock_all));

  // Slot rotation
  always_ff @(posedge clk_cog or posedge res) begin
    if (res)          bus_sel <= NCOG'(1);
    else if (ena_bus) bus_sel <= {bus_sel[NCOG-2:0], bus_sel[NCOG-1]};
  end

  // Stage p1: capture request from the current slot owner
  always_ff @(posedge clk_cog or posedge res) begin
    if (res)          vld_p1 <= 1'b0;
    else if (ena_bus) vld_p1 <= req_e;
  end

  always_ff @(posedge clk_cog) begin
    if (ena_bus) begin
      op_p1  <= hub_op_e'(req_op);
      d_p1   <= req_d;
      rid_p1 <= enc_oh(bus_sel);
    end
  end

  // Execute: next state for the captured request
  always_comb begin
    cog_id  = d_p1[ID_LSB +: CW];
    lock_id = d_p1[ID_LSB +: LW];
    lock_ok = (32'(lock_id) < NLOCK);
    newx    = d_p1[NEWX_BIT];
    cog_tgt = newx ? cog_free : cog_id;

    cog_e_n   = cog_e;
    lock_e_n  = lock_e;
    lock_st_n = lock_st;
    owner_n   = owner;
    cfg_n     = cfg;
    rsp_q_n   = rsp_q;
    rsp_c_n   = rsp_c;
    ptr_w_n   = '0;

    if (vld_p1) begin
      rsp_q_n = '0;
      // Default flag is the "all busy" of the class chosen by op[2]; this
      // also yields rsp_c=1 for a COGINIT newx that finds no free cog.
      rsp_c_n = op_p1[2] ? lock_all : cog_all;
      case (op_p1)
        OP_CLKSET:  cfg_n = d_p1[CFG_W-1:0];
        OP_COGID:   rsp_q_n = RSP_Q_W'(rid_p1);
        OP_COGINIT: begin
          if (!(newx && cog_all)) begin
            cog_e_n[cog_tgt] = 1'b1;
            ptr_w_n[cog_tgt] = 1'b1;
            rsp_q_n          = RSP_Q_W'(cog_tgt);
          end
        end
        OP_COGSTOP: begin
          cog_e_n[cog_id] = 1'b0;
          if (OWN_REL) begin
            for (int i = 0; i < NLOCK; i++) begin
              if (owner[i] == cog_id) lock_e_n[i] = 1'b0;
            end
          end
        end
        OP_LOCKNEW: begin
          rsp_q_n = RSP_Q_W'(lock_free);
          if (!lock_all) begin
            lock_e_n[lock_free] = 1'b1;
            owner_n[lock_free]  = rid_p1;
          end
        end
        OP_LOCKRET: begin
          if (lock_ok) lock_e_n[lock_id] = 1'b0;
        end
        OP_LOCKSET, OP_LOCKCLR: begin
          if (lock_ok) begin
            rsp_c_n            = lock_st[lock_id];
            lock_st_n[lock_id] = ~op_p1[0];
          end
        end
      endcase
    end
  end

  // Stage p2: commit state and register the response
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      vld_p2    <= 1'b0;
      cog_e     <= NCOG'(1);
      cog_ena_r <= '0;
      lock_e    <= '0;
      lock_st   <= '0;
      for (int i = 0; i < NLOCK; i++) owner[i] <= '0;
      cfg       <= '0;
      rsp_q     <= '0;
      rsp_c     <= 1'b0;
      ptr_w     <= '0;
    end else begin
      // Strobe lasts exactly one clock regardless of ena_bus.
      ptr_w <= ena_bus ? ptr_w_n : '0;
      if (ena_bus) begin
        vld_p2    <= vld_p1;
        cog_ena_r <= cog_e;
        cog_e     <= cog_e_n;
        lock_e    <= lock_e_n;
        lock_st   <= lock_st_n;
        owner     <= owner_n;
        cfg       <= cfg_n;
        rsp_q     <= rsp_q_n;
        rsp_c     <= rsp_c_n;
      end
    end
  end

  always_ff @(posedge clk_cog) begin
    if (ena_bus) begin
      rid_p2 <= rid_p1;
      ptr_p2 <= d_p1[PTR_MSB:PTR_LSB];
    end
  end

  // A cog being (re)started is held off while its start pointer is written.
  assign cog_ena = cog_ena_r & ~ptr_w;
  assign rsp_ack = vld_p2 ? (NCOG'(1) << rid_p2) : '0;
  assign ptr_d   = ptr_p2;

endmodule

// File: tb/tb_hub_sys.sv
module tb_hub_sys;
  import hub_pkg::*;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        ena_bus = 1'b0, req_e = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_d = '0;
  logic [7:0]  bus_sel, rsp_ack, cog_ena, ptr_w, cfg;
  logic [4:0]  rsp_q;
  logic        rsp_c;
  logic [25:0] ptr_d;

  logic        ena2 = 1'b0, req_e2 = 1'b0;
  logic [2:0]  req_op2 = '0;
  logic [31:0] req_d2 = '0;
  logic [15:0] bus_sel2, rsp_ack2, cog_ena2, ptr_w2;
  logic [4:0]  rsp_q2;
  logic        rsp_c2;
  logic [25:0] ptr_d2;
  logic [7:0]  cfg2;

  always #5 clk = ~clk;

  hub_sys dut (
    .clk_cog(clk), .res(res), .ena_bus(ena_bus), .bus_sel(bus_sel),
    .req_e(req_e), .req_op(req_op), .req_d(req_d), .rsp_q(rsp_q),
    .rsp_c(rsp_c), .rsp_ack(rsp_ack), .cog_ena(cog_ena), .ptr_w(ptr_w),
    .ptr_d(ptr_d), .cfg(cfg)
  );

  hub_sys #(.NCOG(16), .NLOCK(32), .OWN_REL(1'b1)) dut2 (
    .clk_cog(clk), .res(res), .ena_bus(ena2), .bus_sel(bus_sel2),
    .req_e(req_e2), .req_op(req_op2), .req_d(req_d2), .rsp_q(rsp_q2),
    .rsp_c(rsp_c2), .rsp_ack(rsp_ack2), .cog_ena(cog_ena2), .ptr_w(ptr_w2),
    .ptr_d(ptr_d2), .cfg(cfg2)
  );

  typedef struct {
    logic [2:0]  slot;
    logic [2:0]  op;
    logic [31:0] d;
    bit          chkq;
    logic [4:0]  q;
    logic        c;
    logic [7:0]  ptrw;
    logic [7:0]  ena;
  } vec_t;

  typedef struct {
    int          due;
    logic [7:0]  ack;
    bit          chkq;
    logic [4:0]  q;
    logic        c;
    logic [7:0]  ptrw;
    logic [7:0]  ena;
    logic [25:0] ptrd;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   nchk = 0, nerr = 0;
  int   npulse = 0, cur = 0, cur2 = 0;

  function automatic logic [31:0] mkd(input logic [25:0] ptr, input logic nx, input logic [4:0] id);
    return {ptr, nx, id};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input int slot, input logic [2:0] op, input logic [31:0] d, input bit chkq,
                     input int q, input logic c, input logic [7:0] ptrw, input logic [7:0] ena);
    vec_t v;
    v.slot = 3'(slot); v.op = op; v.d = d; v.chkq = chkq;
    v.q = 5'(q); v.c = c; v.ptrw = ptrw; v.ena = ena;
    vq.push_back(v);
  endtask

  // One hub slot on the 8-cog instance; checks slot rotation and any due response.
  task automatic pulse(input logic e, input logic [2:0] op, input logic [31:0] d);
    exp_t x;
    logic [7:0] sel;
    @(negedge clk);
    req_e = e; req_op = op; req_d = d; ena_bus = 1'b1;
    @(posedge clk); #1;
    ena_bus = 1'b0; req_e = 1'b0;
    npulse++;
    cur = (cur + 1) % 8;
    sel = 8'h01 << cur;
    chk("bus_sel", 32'(bus_sel), 32'(sel));
    if (sb.size() > 0 && sb[0].due == npulse) begin
      x = sb.pop_front();
      chk("rsp_ack", 32'(rsp_ack), 32'(x.ack));
      if (x.chkq) chk("rsp_q", 32'(rsp_q), 32'(x.q));
      chk("rsp_c", 32'(rsp_c), 32'(x.c));
      chk("ptr_w", 32'(ptr_w), 32'(x.ptrw));
      chk("cog_ena", 32'(cog_ena), 32'(x.ena));
      if (x.ptrw != 0) chk("ptr_d", 32'(ptr_d), 32'(x.ptrd));
    end else begin
      chk("ack_idle", 32'(rsp_ack), 32'h0);
      chk("ptrw_idle", 32'(ptr_w), 32'h0);
    end
  endtask

  // Wait for the vector's slot, capture it, optionally stall, and queue the expectation.
  task automatic issue(input vec_t v, input int hold);
    exp_t x;
    logic [7:0] sel;
    while (cur != int'(v.slot)) pulse(1'b0, 3'd0, 32'd0);
    x.due = npulse + 2;
    x.ack = 8'h01 << v.slot;
    x.chkq = v.chkq; x.q = v.q; x.c = v.c;
    x.ptrw = v.ptrw; x.ena = v.ena; x.ptrd = v.d[31:6];
    sb.push_back(x);
    pulse(1'b1, v.op, v.d);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      sel = 8'h01 << cur;
      chk("hold_ack", 32'(rsp_ack), 32'h0);
      chk("hold_sel", 32'(bus_sel), 32'(sel));
    end
  endtask

  task automatic pulse2(input logic e, input logic [2:0] op, input logic [31:0] d);
    @(negedge clk);
    req_e2 = e; req_op2 = op; req_d2 = d; ena2 = 1'b1;
    @(posedge clk); #1;
    ena2 = 1'b0; req_e2 = 1'b0;
    cur2 = (cur2 + 1) % 16;
  endtask

  initial begin
    vec_t hv;

    // slot, op, d, check q, q, c, ptr_w, cog_ena at response
    add(3, OP_COGINIT, mkd(26'h1234, 1, 0), 1, 1, 0, 8'h02, 8'h01);
    add(5, OP_COGID,   mkd(0, 0, 0),        1, 5, 0, 8'h00, 8'h03);
    add(6, OP_CLKSET,  32'h0000_00A5,       0, 0, 0, 8'h00, 8'h03);
    add(0, OP_COGINIT, mkd(26'h10, 1, 0),   1, 2, 0, 8'h04, 8'h03);
    add(1, OP_COGINIT, mkd(26'h11, 1, 0),   1, 3, 0, 8'h08, 8'h07);
    add(2, OP_COGINIT, mkd(26'h12, 1, 0),   1, 4, 0, 8'h10, 8'h0F);
    add(3, OP_COGINIT, mkd(26'h13, 1, 0),   1, 5, 0, 8'h20, 8'h1F);
    add(4, OP_COGINIT, mkd(26'h14, 1, 0),   1, 6, 0, 8'h40, 8'h3F);
    add(5, OP_COGINIT, mkd(26'h15, 1, 0),   1, 7, 0, 8'h80, 8'h7F);
    add(6, OP_COGINIT, mkd(26'h16, 1, 0),   0, 0, 1, 8'h00, 8'hFF);
    add(7, OP_COGINIT, mkd(26'hABC, 0, 5),  1, 5, 1, 8'h20, 8'hDF);
    add(2, OP_LOCKNEW, 32'd0,               1, 0, 0, 8'h00, 8'hFF);
    add(3, OP_LOCKSET, 32'd0,               0, 0, 0, 8'h00, 8'hFF);
    add(4, OP_LOCKSET, 32'd0,               0, 0, 1, 8'h00, 8'hFF);
    add(4, OP_LOCKNEW, 32'd0,               1, 1, 0, 8'h00, 8'hFF);
    add(5, OP_LOCKCLR, 32'd0,               0, 0, 1, 8'h00, 8'hFF);
    add(6, OP_LOCKSET, 32'd8,               0, 0, 0, 8'h00, 8'hFF);
    add(2, OP_COGSTOP, 32'd2,               0, 0, 1, 8'h00, 8'hFF);
    add(3, OP_LOCKNEW, 32'd0,               1, 0, 0, 8'h00, 8'hFB);
    add(0, OP_LOCKRET, 32'd1,               0, 0, 0, 8'h00, 8'hFB);
    add(1, OP_LOCKNEW, 32'd0,               1, 1, 0, 8'h00, 8'hFB);
    add(7, OP_COGINIT, mkd(26'h0, 1, 0),    1, 2, 0, 8'h04, 8'hFB);
    add(0, OP_COGSTOP, 32'd4,               0, 0, 1, 8'h00, 8'hFF);
    add(0, OP_LOCKNEW, 32'd0,               1, 2, 0, 8'h00, 8'hEF);
    add(7, OP_COGID,   32'd0,               1, 7, 0, 8'h00, 8'hEF);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_bus_sel", 32'(bus_sel), 32'h01);
    chk("rst_cog_ena", 32'(cog_ena), 32'h00);
    chk("rst_ack", 32'(rsp_ack), 32'h00);
    chk("rst_ptr_w", 32'(ptr_w), 32'h00);
    chk("rst_cfg", 32'(cfg), 32'h00);
    chk("rst_rsp", {rsp_c, rsp_q}, 32'h0);
    res = 1'b0;

    // Slot rotation across 16 pulses
    for (int i = 0; i < 16; i++) begin
      pulse(1'b0, 3'd0, 32'd0);
      if (i == 0) chk("cog_ena_first", 32'(cog_ena), 32'h01);
    end

    foreach (vq[i]) issue(vq[i], 0);
    pulse(1'b0, 3'd0, 32'd0);
    pulse(1'b0, 3'd0, 32'd0);
    chk("cfg", 32'(cfg), 32'hA5);

    // Pipeline holds while ena_bus is low
    hv.slot = 3'(cur); hv.op = OP_COGID; hv.d = 32'd0; hv.chkq = 1'b1;
    hv.q = 5'(cur); hv.c = 1'b0; hv.ptrw = 8'h00; hv.ena = 8'hEF;
    issue(hv, 3);
    pulse(1'b0, 3'd0, 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Reset between capture and execute of a COGINIT discards it
    pulse(1'b1, OP_COGINIT, mkd(26'h55, 1, 0));
    @(negedge clk);
    res = 1'b1;
    #1;
    chk("midrst_bus_sel", 32'(bus_sel), 32'h01);
    chk("midrst_ack", 32'(rsp_ack), 32'h00);
    chk("midrst_ptr_w", 32'(ptr_w), 32'h00);
    chk("midrst_cog_ena", 32'(cog_ena), 32'h00);
    @(negedge clk);
    res = 1'b0;
    cur = 0; cur2 = 0;
    pulse(1'b0, 3'd0, 32'd0);
    chk("midrst_ena1", 32'(cog_ena), 32'h01);
    pulse(1'b0, 3'd0, 32'd0);
    chk("midrst_ena2", 32'(cog_ena), 32'h01);
    hv.slot = 3'd1; hv.op = OP_COGINIT; hv.d = mkd(26'h3F, 1, 0); hv.chkq = 1'b1;
    hv.q = 5'd1; hv.c = 1'b0; hv.ptrw = 8'h02; hv.ena = 8'h01;
    issue(hv, 0);
    pulse(1'b0, 3'd0, 32'd0);
    pulse(1'b0, 3'd0, 32'd0);
    chk("post_rst_ena", 32'(cog_ena), 32'h03);

    // 16-cog / 32-lock instance: CLKSET and COGID from the top slot
    pulse2(1'b1, OP_CLKSET, 32'h0000_016F);
    pulse2(1'b0, 3'd0, 32'd0);
    chk("cfg2", 32'(cfg2), 32'h6F);
    while (cur2 != 15) pulse2(1'b0, 3'd0, 32'd0);
    chk("bus_sel2", 32'(bus_sel2), 32'h8000);
    pulse2(1'b1, OP_COGID, 32'd0);
    chk("ack2_early", 32'(rsp_ack2), 32'h0);
    pulse2(1'b0, 3'd0, 32'd0);
    chk("ack2", 32'(rsp_ack2), 32'h8000);
    chk("rsp_q2", 32'(rsp_q2), 32'd15);
    chk("rsp_c2", 32'(rsp_c2), 32'd0);
    chk("ptr_w2", 32'(ptr_w2), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
